// File: rtl/servo_pkg.sv
// Shared types and helpers for the pan/tilt servo controller: FSM encoding,
// pulse-width scale factor and saturating one-degree angle step.
package servo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_TRACK  = 2'd2,
      ST_HOME   = 2'd3
   } servo_state_t;

   // Microseconds of pulse width per degree, Q8 fixed point, truncated.
   function automatic int us_per_deg_q8(input int pw_min_us, input int pw_max_us,
                                        input int angle_max);
      return ((pw_max_us - pw_min_us) << 8) / angle_max;
   endfunction

   function automatic logic [7:0] sat_step(input logic [7:0] angle, input logic inc,
                                           input logic dec, input logic [7:0] angle_max);
      logic [7:0] res;
      res = angle;
      if (inc && !dec && (angle < angle_max)) begin
         res = angle + 8'd1;
      end else if (dec && !inc && (angle != 8'd0)) begin
         res = angle - 8'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// One servo PWM channel: angle shadowed at frame start, pulse high while
// frame_us is below the scaled pulse width; output registered.
module servo_pwm_gen #(
   parameter int FW            = 15,
   parameter int PW_MIN_US     = 500,
   parameter int US_PER_DEG_Q8 = 2844,
   parameter logic [7:0] ANGLE_INIT = 8'd90
) (
   input  logic          hclk_i,
   input  logic          hreset_i,
   input  logic [FW-1:0] frame_us_i,
   input  logic [7:0]    angle_i,
   output logic          pwm_o
);

   logic [7:0]  shadow_q, shadow_d;
   logic        pwm_q, pwm_d;
   logic [31:0] pw_us;

   // Width is only taken from the shadow, so a mid-frame angle change cannot
   // shorten or stretch the pulse already in progress.
   assign pw_us = 32'(PW_MIN_US) + (({24'd0, shadow_q} * 32'(US_PER_DEG_Q8)) >> 8);

   always_comb begin
      shadow_d = shadow_q;
      if (frame_us_i == '0) begin
         shadow_d = angle_i;
      end
      pwm_d = (32'(frame_us_i) < pw_us);
   end

   always_ff @(posedge hclk_i) begin
      if (hreset_i) begin
         shadow_q <= ANGLE_INIT;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_pan_tilt_ctrl.sv
// Pan/tilt hobby-servo controller: timebase, jog/track/home FSM, angle state and
// two PWM channels. Define SERVO_HOME_RAMP_EN for slew-limited homing.
//
//   state  | meaning
//   IDLE   | no motion, waiting for a command
//   MANUAL | jogging from direction inputs, 1 deg per step
//   TRACK  | closed-loop tracking from pending dx/dy errors
//   HOME   | returning both axes to ANGLE_INIT
module servo_pan_tilt_ctrl
   import servo_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int FRAME_US    = 20000,
   parameter int PW_MIN_US   = 500,
   parameter int PW_MAX_US   = 2500,
   parameter int ANGLE_MAX   = 180,
   parameter int ANGLE_INIT  = 90,
   parameter int STEP_MS     = 10,
   parameter int TRACK_DB    = 4
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              Servo_up,
   input  logic              Servo_down,
   input  logic              Servo_left,
   input  logic              Servo_right,
   input  logic              Servo_rst,
   input  logic              Servo_track_en,
   input  logic              track_vld,
   input  logic signed [7:0] track_dx,
   input  logic signed [7:0] track_dy,
   output logic              pan_pwm,
   output logic              tilt_pwm,
   output logic [7:0]        pan_angle,
   output logic [7:0]        tilt_angle,
   output logic              busy,
   output logic              frame_start
);

   localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
   localparam int STEP_US    = STEP_MS * 1000;
   localparam int PS_W       = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
   localparam int FW         = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam int SW         = (STEP_US > 1) ? $clog2(STEP_US) : 1;
   localparam int Q8         = us_per_deg_q8(PW_MIN_US, PW_MAX_US, ANGLE_MAX);

   localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CYC_PER_US - 1);
   localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAME_US - 1);
   localparam logic [SW-1:0]   STEP_LAST  = SW'(STEP_US - 1);
   localparam logic [7:0]      A_MAX      = 8'(ANGLE_MAX);
   localparam logic [7:0]      A_INIT     = 8'(ANGLE_INIT);
   localparam logic signed [7:0] DB_POS   = 8'(TRACK_DB);
   localparam logic signed [7:0] DB_NEG   = 8'(-TRACK_DB);

   logic [PS_W-1:0] ps_q, ps_d;
   logic [FW-1:0]   frame_us_q, frame_us_d;
   logic [SW-1:0]   step_us_q, step_us_d;
   logic            frame_start_q, frame_start_d;
   servo_state_t    state_q, state_d;
   logic [7:0]      pan_q, pan_d, tilt_q, tilt_d;
   logic signed [7:0] pend_dx_q, pend_dx_d, pend_dy_q, pend_dy_d;

   logic us_tick, step_tick, dir_any;

   assign us_tick   = (ps_q == PS_LAST);
   assign step_tick = us_tick && (step_us_q == STEP_LAST);
   assign dir_any   = Servo_up | Servo_down | Servo_left | Servo_right;

   always_comb begin
      ps_d          = us_tick ? '0 : ps_q + PS_W'(1);
      frame_us_d    = frame_us_q;
      step_us_d     = step_us_q;
      frame_start_d = 1'b0;
      if (us_tick) begin
         if (frame_us_q == FRAME_LAST) begin
            frame_us_d    = '0;
            frame_start_d = 1'b1;
         end else begin
            frame_us_d = frame_us_q + FW'(1);
         end
         step_us_d = (step_us_q == STEP_LAST) ? '0 : step_us_q + SW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      if (Servo_rst) begin
         state_d = ST_HOME;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Servo_track_en)  state_d = ST_TRACK;
               else if (dir_any)    state_d = ST_MANUAL;
            end
            ST_MANUAL: begin
               if (Servo_track_en)  state_d = ST_TRACK;
               else if (!dir_any)   state_d = ST_IDLE;
            end
            ST_TRACK: begin
               if (!Servo_track_en) state_d = ST_IDLE;
            end
            ST_HOME: begin
               if ((pan_q == A_INIT) && (tilt_q == A_INIT)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Pending errors are held only while tracking continues; any exit drops them.
   always_comb begin
      pan_d     = pan_q;
      tilt_d    = tilt_q;
      pend_dx_d = '0;
      pend_dy_d = '0;
      case (state_q)
         ST_MANUAL: begin
            if (step_tick && !Servo_rst) begin
               tilt_d = sat_step(tilt_q, Servo_up, Servo_down, A_MAX);
               pan_d  = sat_step(pan_q, Servo_right, Servo_left, A_MAX);
            end
         end
         ST_TRACK: begin
            if (state_d == ST_TRACK) begin
               pend_dx_d = pend_dx_q;
               pend_dy_d = pend_dy_q;
               if (step_tick) begin
                  pan_d     = sat_step(pan_q, pend_dx_q > DB_POS, pend_dx_q < DB_NEG, A_MAX);
                  tilt_d    = sat_step(tilt_q, pend_dy_q > DB_POS, pend_dy_q < DB_NEG, A_MAX);
                  pend_dx_d = '0;
                  pend_dy_d = '0;
               end
               if (track_vld) begin
                  pend_dx_d = track_dx;
                  pend_dy_d = track_dy;
               end
            end
         end
         ST_HOME: begin
`ifdef SERVO_HOME_RAMP_EN
            if (step_tick) begin
               pan_d  = sat_step(pan_q, pan_q < A_INIT, pan_q > A_INIT, A_MAX);
               tilt_d = sat_step(tilt_q, tilt_q < A_INIT, tilt_q > A_INIT, A_MAX);
            end
`else
            pan_d  = A_INIT;
            tilt_d = A_INIT;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ps_q          <= '0;
         frame_us_q    <= '0;
         step_us_q     <= '0;
         frame_start_q <= 1'b0;
         state_q       <= ST_IDLE;
         pan_q         <= A_INIT;
         tilt_q        <= A_INIT;
         pend_dx_q     <= '0;
         pend_dy_q     <= '0;
      end else begin
         ps_q          <= ps_d;
         frame_us_q    <= frame_us_d;
         step_us_q     <= step_us_d;
         frame_start_q <= frame_start_d;
         state_q       <= state_d;
         pan_q         <= pan_d;
         tilt_q        <= tilt_d;
         pend_dx_q     <= pend_dx_d;
         pend_dy_q     <= pend_dy_d;
      end
   end

   servo_pwm_gen #(
      .FW            (FW),
      .PW_MIN_US     (PW_MIN_US),
      .US_PER_DEG_Q8 (Q8),
      .ANGLE_INIT    (A_INIT)
   ) u_pan_pwm (
      .hclk_i     (HCLK),
      .hreset_i   (HRESET),
      .frame_us_i (frame_us_q),
      .angle_i    (pan_q),
      .pwm_o      (pan_pwm)
   );

   servo_pwm_gen #(
      .FW            (FW),
      .PW_MIN_US     (PW_MIN_US),
      .US_PER_DEG_Q8 (Q8),
      .ANGLE_INIT    (A_INIT)
   ) u_tilt_pwm (
      .hclk_i     (HCLK),
      .hreset_i   (HRESET),
      .frame_us_i (frame_us_q),
      .angle_i    (tilt_q),
      .pwm_o      (tilt_pwm)
   );

   assign pan_angle   = pan_q;
   assign tilt_angle  = tilt_q;
   assign busy        = (state_q != ST_IDLE);
   assign frame_start = frame_start_q;

endmodule
